piccolo80_dec_iter: RTL

- Iterative Piccolo-80 decryption core: one round per clock, 64-bit block, 80-bit runtime key.
- Inverse partner of the unrolled Piccolo-80 encryption datapath. Reuses the encryption round structure with the decryption key transformation.
- Sits behind a valid/ready stream interface so it can be chained with the encryptor for loopback checking.

---
 rtl/piccolo_pkg.sv | 62 ++++++
 rtl/piccolo80_dec_ksched.sv | 54 +++++
 rtl/piccolo80_dec_iter.sv | 107 ++++++++++
 3 files changed

// File: rtl/piccolo_pkg.sv
// piccolo_pkg
//   Shared definitions for the Piccolo-80 cores: round count, FSM state
//   encoding and the round primitives (nibble S-box, GF(2^4) doubling and
//   tripling, F function, byte permutation RP, round constant CON80).
//   Words and bytes are numbered MSB-first: X0 / byte 0 is the top of a vector.
package piccolo_pkg;

    localparam int NR = 25;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'he;  4'h1: y = 4'h4;  4'h2: y = 4'hb;  4'h3: y = 4'h2;
            4'h4: y = 4'h3;  4'h5: y = 4'h8;  4'h6: y = 4'h0;  4'h7: y = 4'h9;
            4'h8: y = 4'h1;  4'h9: y = 4'ha;  4'ha: y = 4'h7;  4'hb: y = 4'hf;
            4'hc: y = 4'h6;  4'hd: y = 4'hc;  4'he: y = 4'h5;  4'hf: y = 4'hd;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Multiply by x modulo x^4 + x + 1: the carried-out x^4 folds back as 0011.
    function automatic logic [3:0] gf_x2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    function automatic logic [3:0] gf_x3(input logic [3:0] a);
        return gf_x2(a) ^ a;
    endfunction

    // S-box layer, circulant MixColumn (2,3,1,1), S-box layer.
    function automatic logic [15:0] f_func(input logic [15:0] x);
        logic [3:0] s0, s1, s2, s3;
        logic [3:0] m0, m1, m2, m3;
        s0 = sbox(x[15:12]);
        s1 = sbox(x[11:8]);
        s2 = sbox(x[7:4]);
        s3 = sbox(x[3:0]);
        m0 = gf_x2(s0) ^ gf_x3(s1) ^ s2        ^ s3;
        m1 = s0        ^ gf_x2(s1) ^ gf_x3(s2) ^ s3;
        m2 = s0        ^ s1        ^ gf_x2(s2) ^ gf_x3(s3);
        m3 = gf_x3(s0) ^ s1        ^ s2        ^ gf_x2(s3);
        return {sbox(m0), sbox(m1), sbox(m2), sbox(m3)};
    endfunction

    // Bytes (x0..x7) -> (x2,x7,x4,x1,x6,x3,x0,x5).
    function automatic logic [63:0] rp(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48],
                x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    // Constant pair for encryption round j, packed {con_2j, con_2j+1}.
    function automatic logic [31:0] con80(input logic [4:0] j);
        logic [4:0] c;
        c = j + 5'd1;
        return {c, 5'b00000, c, 2'b00, c, 5'b00000, c} ^ 32'h0f1e2d3c;
    endfunction

endpackage

// File: rtl/piccolo80_dec_ksched.sv
// piccolo80_dec_ksched
//   Combinational decryption key schedule.
//   key_i   : 80-bit master key, k0 = key_i[79:64] ... k4 = key_i[15:0]
//   round_i : decryption round index i (0..NR-1)
//   rk_a_o  : rk'2i,   rk_b_o : rk'2i+1
//   wk0_o..wk3_o : decryption whitening keys wk'0..wk'3
module piccolo80_dec_ksched
    import piccolo_pkg::*;
(
    input  logic [79:0] key_i,
    input  logic [4:0]  round_i,
    output logic [15:0] rk_a_o,
    output logic [15:0] rk_b_o,
    output logic [15:0] wk0_o,
    output logic [15:0] wk1_o,
    output logic [15:0] wk2_o,
    output logic [15:0] wk3_o
);

    logic [15:0] k0, k1, k2, k3, k4;
    logic [4:0]  enc_round;
    logic [31:0] pair;

    assign k0 = key_i[79:64];
    assign k1 = key_i[63:48];
    assign k2 = key_i[47:32];
    assign k3 = key_i[31:16];
    assign k4 = key_i[15:0];

    // Decryption walks the encryption round keys backwards.
    assign enc_round = 5'(NR - 1) - round_i;

    always_comb begin
        // NOTE: every combinational output is given a default first so no latch can be inferred.
        pair = {k2, k3};
        case (enc_round % 5'd5)
            5'd1, 5'd4: pair = {k0, k1};
            5'd3:       pair = {k4, k4};
            default:    pair = {k2, k3};
        endcase
        pair = pair ^ con80(enc_round);
    end

    // Odd decryption rounds take the pair swapped to undo the RP word order.
    assign rk_a_o = round_i[0] ? pair[15:0]  : pair[31:16];
    assign rk_b_o = round_i[0] ? pair[31:16] : pair[15:0];

    // Decryption whitening is the encryption whitening with the two halves exchanged.
    assign wk0_o = {k4[15:8], k3[7:0]};
    assign wk1_o = {k3[15:8], k4[7:0]};
    assign wk2_o = {k0[15:8], k1[7:0]};
    assign wk3_o = {k1[15:8], k0[7:0]};

endmodule

// File: rtl/piccolo80_dec_iter.sv
// piccolo80_dec_iter
//   Iterative Piccolo-80 decryption, one round per clock, valid/ready streams.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   in_valid/ready : ciphertext + key handshake; in_ready high only in IDLE
//   key            : 80-bit master key, k0 in [79:64] (MSB-first)
//   ciphertext     : 64-bit block, X0 in [63:48]
//   out_valid/ready: plaintext handshake; plaintext holds its last value
//   Latency: out_valid rises NR clocks after the accept edge.
module piccolo80_dec_iter
    import piccolo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] key,
    input  logic [63:0] ciphertext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext
);

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  round_q, round_d;
    logic [63:0] pt_q, pt_d;

    logic [79:0] ks_key;
    logic [15:0] rk_a, rk_b, wk0, wk1, wk2, wk3;
    logic [15:0] x1_n, x3_n;
    logic [63:0] rnd;

    // In IDLE the schedule sees the incoming key so the accept edge can apply
    // input whitening; round keys are not used there.
    assign ks_key = (state_q == IDLE) ? key : key_q;

    piccolo80_dec_ksched u_ksched (
        .key_i   (ks_key),
        .round_i (round_q),
        .rk_a_o  (rk_a),
        .rk_b_o  (rk_b),
        .wk0_o   (wk0),
        .wk1_o   (wk1),
        .wk2_o   (wk2),
        .wk3_o   (wk3)
    );

    assign x1_n = data_q[47:32] ^ f_func(data_q[63:48]) ^ rk_a;
    assign x3_n = data_q[15:0]  ^ f_func(data_q[31:16]) ^ rk_b;
    assign rnd  = {data_q[63:48], x1_n, data_q[31:16], x3_n};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        round_d = round_q;
        pt_d    = pt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    key_d   = key;
                    data_d  = ciphertext ^ {wk0, 16'h0000, wk1, 16'h0000};
                    round_d = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (round_q == 5'(NR - 1)) begin
                    // Final round: no RP, output whitening straight into plaintext.
                    pt_d    = rnd ^ {wk2, 16'h0000, wk3, 16'h0000};
                    state_d = DONE;
                end else begin
                    data_d  = rp(rnd);
                    round_d = round_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are reset too, so reset leaves no stale key or partial block visible.
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            round_q <= '0;
            pt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            round_q <= round_d;
            pt_q    <= pt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign plaintext = pt_q;

endmodule
